// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: spins a die face while roll is held, then settles.
// Optional slowdown phase enabled by defining DICE_SLOWDOWN_EN.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   roll - roll request level (synchronized, debounced)
//   face - die value, 0 = blank, 1..6 = pips
//   busy - high while rolling or slowing down
//   done - one-cycle pulse when the result settles
module dice_roll_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int SLOW_STEPS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll,
    output logic [2:0] face,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROLL = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd3;
`ifdef DICE_SLOWDOWN_EN
    localparam logic [1:0] S_SLOW = 2'd2;
    localparam logic [3:0] LAST_K = 4'(SLOW_STEPS - 1);
`endif

    if (TICK_DIV < 2 || SLOW_STEPS < 1 || SLOW_STEPS > 15) begin : g_bad_param
        $error("dice_roll_ctrl: TICK_DIV or SLOW_STEPS out of range");
    end

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [2:0]    face_n;
`ifdef DICE_SLOWDOWN_EN
    logic [3:0]    k;
    logic [3:0]    k_n;
    logic [3:0]    wcnt;
    logic [3:0]    wcnt_n;
`endif

    assign tick = (cnt == CW'(TICK_DIV - 1));

    function automatic logic [2:0] advance(input logic [2:0] f);
        // 0 (blank) and 6 both step to 1; 7 is never reachable
        if (f == 3'd0 || f >= 3'd6)
            return 3'd1;
        return f + 3'd1;
    endfunction

    always_comb begin
        state_n = state;
        face_n  = face;
`ifdef DICE_SLOWDOWN_EN
        k_n     = k;
        wcnt_n  = wcnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (roll)
                    state_n = S_ROLL;
            end
            S_ROLL: begin
                if (!roll) begin
`ifdef DICE_SLOWDOWN_EN
                    state_n = S_SLOW;
                    k_n     = 4'd0;
                    wcnt_n  = 4'd0;
`else
                    state_n = S_SHOW;
`endif
                end else if (tick) begin
                    face_n = advance(face);
                end
            end
`ifdef DICE_SLOWDOWN_EN
            S_SLOW: begin
                if (roll) begin
                    state_n = S_ROLL;
                end else if (tick) begin
                    // wait count would reach k+1 on this tick
                    if (wcnt == k) begin
                        face_n = advance(face);
                        wcnt_n = 4'd0;
                        k_n    = k + 4'd1;
                        if (k == LAST_K)
                            state_n = S_SHOW;
                    end else begin
                        wcnt_n = wcnt + 4'd1;
                    end
                end
            end
`endif
            S_SHOW: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            state <= S_IDLE;
            face  <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DICE_SLOWDOWN_EN
            k     <= 4'd0;
            wcnt  <= 4'd0;
`endif
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            state <= state_n;
            face  <= face_n;
`ifdef DICE_SLOWDOWN_EN
            busy  <= (state_n == S_ROLL) || (state_n == S_SLOW);
            k     <= k_n;
            wcnt  <= wcnt_n;
`else
            busy  <= (state_n == S_ROLL);
`endif
            done  <= (state_n == S_SHOW);
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl (TICK_DIV=4, SLOW_STEPS=3).
// Follows DICE_SLOWDOWN_EN the same way the design does.
module tb_dice_roll_ctrl;

    localparam int TD = 4;
    localparam int SS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       roll = 1'b0;
    logic [2:0] face;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    // reference model: 0 idle, 1 rolling, 2 slowing, 3 showing
    int m_mode = 0;
    int m_face = 0;
    int m_edges = 0;
    int m_st = 0;
    int m_adv = 0;

`ifdef DICE_SLOWDOWN_EN
    localparam bit SLOWDOWN = 1'b1;
`else
    localparam bit SLOWDOWN = 1'b0;
`endif

    always #5 clk = ~clk;

    dice_roll_ctrl #(
        .TICK_DIV(TD),
        .SLOW_STEPS(SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .roll(roll),
        .face(face),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge of the behavioural model, inputs as seen before the edge.
    task automatic model_step(input logic r, input logic rl);
        bit tk;
        if (r) begin
            m_mode = 0;
            m_face = 0;
            m_edges = 0;
            return;
        end
        tk = (m_edges % TD) == TD - 1;
        m_edges++;
        case (m_mode)
            0: if (rl) m_mode = 1;
            1: begin
                if (!rl) begin
                    m_mode = SLOWDOWN ? 2 : 3;
                    m_st = 0;
                    m_adv = 0;
                end else if (tk) begin
                    m_face = (m_face % 6) + 1;
                end
            end
            2: begin
                if (rl) begin
                    m_mode = 1;
                end else if (tk) begin
                    m_st++;
                    // n-th slow advance lands after 1+2+..+n slow ticks
                    if (m_st == (m_adv + 1) * (m_adv + 2) / 2) begin
                        m_face = (m_face % 6) + 1;
                        m_adv++;
                        if (m_adv == SS) m_mode = 3;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic cyc(input logic r, input logic rl);
        rst = r;
        roll = rl;
        @(posedge clk);
        model_step(r, rl);
        #1;
        check("face", face, m_face);
        check("busy", busy, (m_mode == 1 || m_mode == 2));
        check("done", done, (m_mode == 3));
        check("face_range", (face <= 3'd6), 1);
    endtask

    int done_cnt;
    int wait_cyc;
    bit seen;
    logic [2:0] f0;

    initial begin
        // reset with roll high
        cyc(1, 1);
        cyc(1, 1);
        check("rst_face", face, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // first tick lands TD cycles after release
        for (int i = 0; i < TD - 1; i++) cyc(0, 1);
        check("pre_tick_face", face, 0);
        cyc(0, 1);
        check("first_tick_face", face, 1);
        for (int i = 0; i < 9 * TD; i++) cyc(0, 1);
        check("release_face", face, 4);

        // release and wait for the result
        done_cnt = 0;
        seen = 0;
        wait_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0);
            if (done) begin
                done_cnt++;
                if (!seen) begin
                    wait_cyc = i + 1;
                    check("done_busy", busy, 0);
                    check("settled_face", face, SLOWDOWN ? 1 : 4);
                end
                seen = 1;
            end
        end
        check("done_seen", seen, 1);
        check("done_count", done_cnt, 1);
        if (!SLOWDOWN) check("done_latency", wait_cyc, 1);
        check("idle_busy", busy, 0);

        // re-roll right after the first slow advance
        cyc(1, 0);
        for (int i = 0; i < 3 * TD; i++) cyc(0, 1);
        f0 = face;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(0, 0);
            if (face != f0 || done) seen = 1;
        end
        check("slow_step_seen", seen, 1);
        done_cnt = 0;
        for (int i = 0; i < 5 * TD; i++) begin
            cyc(0, 1);
            if (done) done_cnt++;
        end
        check("reroll_no_done", done_cnt, 0);
        check("reroll_busy", busy, 1);

        // reset in the middle of the settle phase
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);
        check("midrst_face", face, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);

        // roll held through SHOW is ignored; IDLE follows
        for (int i = 0; i < 2 * TD + 1; i++) cyc(0, 1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(0, 0);
            if (done) seen = 1;
        end
        check("show_seen", seen, 1);
        cyc(0, 1);
        check("after_show_busy", busy, 0);
        cyc(0, 1);
        check("reroll_from_idle", busy, 1);

        // random roll toggles with rare resets
        for (int n = 0; n < 1000; n++) begin
            logic rl;
            int len;
            rl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++)
                cyc(($urandom_range(0, 299) == 0), rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
